// File: rtl/move_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : move_scheduler_if
// Description : Command handshake between the move scheduler (master) and the
//               game-logic core (slave): valid/ready plus a 3-bit command code.
// Revision    : 1.0 - initial release
// ============================================================================
interface move_scheduler_if;
   logic       cmd_valid;
   logic [2:0] cmd;
   logic       cmd_ready;

   modport master (output cmd_valid, output cmd, input cmd_ready);
   modport slave  (input cmd_valid, input cmd, output cmd_ready);
endinterface
`default_nettype wire

// File: rtl/move_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : move_scheduler
// Description : Arbitrates one-cycle move requests against a gravity timer and
//               issues one command at a time over a valid/ready handshake.
//               Owns pause/stop, game-over sequencing and the speed level.
//               Optional feature macro: MOVE_SCHED_LEVELUP_EN (level accounting
//               and level-dependent gravity period).
// Revision    : 1.0 - initial release
// ============================================================================
module move_scheduler #(
   parameter int GRAVITY_INIT    = 30_000_000,
   parameter int GRAVITY_MIN     = 3_000_000,
   parameter int SPEEDUP_STEP    = 2_500_000,
   parameter int LINES_PER_LEVEL = 10
) (
   input  wire               clk,
   input  wire               clr,
   input  wire               up,
   input  wire               left,
   input  wire               right,
   input  wire               down,
   input  wire               stop,
   input  wire               game_over,
   input  wire  [2:0]        lines_cleared,
   input  wire               lines_valid,
   move_scheduler_if.master  cmd_if,
   output logic [3:0]        level,
   output logic              paused
);

   typedef enum logic [1:0] {
      S_RUN    = 2'd0,
      S_ISSUE  = 2'd1,
      S_PAUSED = 2'd2,
      S_OVER   = 2'd3
   } state_t;

   localparam logic [2:0]  c_CMD_NONE    = 3'd0;
   localparam logic [2:0]  c_CMD_GRAVITY = 3'd1;
   localparam logic [2:0]  c_CMD_ROTATE  = 3'd2;
   localparam logic [2:0]  c_CMD_LEFT    = 3'd3;
   localparam logic [2:0]  c_CMD_RIGHT   = 3'd4;
   localparam logic [2:0]  c_CMD_SOFT    = 3'd5;
   localparam logic [31:0] c_INIT        = 32'(GRAVITY_INIT);

   state_t      r_state, w_state_nxt;
   logic        r_valid, w_valid_nxt;
   logic [2:0]  r_cmd, w_cmd_nxt;
   logic        r_grav, r_rot, r_hor, r_hdir, r_soft;
   logic [31:0] r_cnt;
   logic [31:0] w_period;
   logic        r_paused;
   logic        w_accept, w_acc_g, w_acc_r, w_acc_h, w_acc_s;
   logic        w_tick, w_expire, w_clear, w_hpulse;
   logic        w_any, w_any_after;
   logic [2:0]  w_pick, w_pick_after;

   // Fixed priority: gravity > rotate > horizontal > soft drop.
   function automatic logic [2:0] f_pick(input logic g, input logic r,
                                         input logic h, input logic hd,
                                         input logic s);
      if (g)      return c_CMD_GRAVITY;
      else if (r) return c_CMD_ROTATE;
      else if (h) return hd ? c_CMD_RIGHT : c_CMD_LEFT;
      else if (s) return c_CMD_SOFT;
      else        return c_CMD_NONE;
   endfunction

   assign w_accept = (r_state == S_ISSUE) && r_valid && cmd_if.cmd_ready;
   assign w_acc_g  = w_accept && (r_cmd == c_CMD_GRAVITY);
   assign w_acc_r  = w_accept && (r_cmd == c_CMD_ROTATE);
   assign w_acc_h  = w_accept && ((r_cmd == c_CMD_LEFT) || (r_cmd == c_CMD_RIGHT));
   assign w_acc_s  = w_accept && (r_cmd == c_CMD_SOFT);

   assign w_any        = r_grav | r_rot | r_hor | r_soft;
   assign w_pick       = f_pick(r_grav, r_rot, r_hor, r_hdir, r_soft);
   // Flags still pending once the command being accepted is removed.
   assign w_any_after  = (r_grav & ~w_acc_g) | (r_rot & ~w_acc_r) |
                         (r_hor & ~w_acc_h) | (r_soft & ~w_acc_s);
   assign w_pick_after = f_pick(r_grav & ~w_acc_g, r_rot & ~w_acc_r,
                                r_hor & ~w_acc_h, r_hdir, r_soft & ~w_acc_s);

   assign w_tick   = (r_state == S_RUN) || (r_state == S_ISSUE);
   assign w_expire = w_tick && (r_cnt == 32'd0);
   // Pulses are discarded while paused/over and on the edge entering either.
   assign w_clear  = (r_state == S_PAUSED) || (r_state == S_OVER) ||
                     (w_state_nxt == S_PAUSED) || (w_state_nxt == S_OVER);
   // Simultaneous left and right cancel out.
   assign w_hpulse = left ^ right;

   // Next-state and registered-command decode.
   always_comb begin
      w_state_nxt = r_state;
      w_valid_nxt = r_valid;
      w_cmd_nxt   = r_cmd;
      if (game_over) begin
         w_state_nxt = S_OVER;
         w_valid_nxt = 1'b0;
         w_cmd_nxt   = c_CMD_NONE;
      end else begin
         case (r_state)
            S_RUN: begin
               if (w_any) begin
                  w_state_nxt = S_ISSUE;
                  w_valid_nxt = 1'b1;
                  w_cmd_nxt   = w_pick;
               end
            end
            S_ISSUE: begin
               if (w_accept) begin
                  if (stop) begin
                     w_state_nxt = S_PAUSED;
                     w_valid_nxt = 1'b0;
                     w_cmd_nxt   = c_CMD_NONE;
                  end else if (w_any_after) begin
                     w_cmd_nxt   = w_pick_after;
                  end else begin
                     w_state_nxt = S_RUN;
                     w_valid_nxt = 1'b0;
                     w_cmd_nxt   = c_CMD_NONE;
                  end
               end
            end
            S_PAUSED: begin
               if (!stop) w_state_nxt = S_RUN;
            end
            default: begin
               w_state_nxt = S_OVER;
               w_valid_nxt = 1'b0;
               w_cmd_nxt   = c_CMD_NONE;
            end
         endcase
      end
   end

   // State and handshake output registers.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         r_state <= S_RUN;
         r_valid <= 1'b0;
         r_cmd   <= c_CMD_NONE;
      end else begin
         r_state <= w_state_nxt;
         r_valid <= w_valid_nxt;
         r_cmd   <= w_cmd_nxt;
      end
   end

   // Pending request flags; a pulse coinciding with acceptance re-sets its flag.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         r_grav <= 1'b0;
         r_rot  <= 1'b0;
         r_hor  <= 1'b0;
         r_hdir <= 1'b0;
         r_soft <= 1'b0;
      end else if (w_clear) begin
         r_grav <= 1'b0;
         r_rot  <= 1'b0;
         r_hor  <= 1'b0;
         r_soft <= 1'b0;
      end else begin
         r_grav <= (r_grav & ~w_acc_g) | w_expire;
         r_rot  <= (r_rot  & ~w_acc_r) | up;
         r_hor  <= (r_hor  & ~w_acc_h) | w_hpulse;
         r_soft <= (r_soft & ~w_acc_s) | down;
         if (w_hpulse) r_hdir <= right;
      end
   end

   // Gravity down-counter; soft-drop acceptance restarts the interval.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         r_cnt <= c_INIT - 32'd1;
      end else if (w_tick) begin
         if (w_expire || w_acc_s) r_cnt <= w_period - 32'd1;
         else                     r_cnt <= r_cnt - 32'd1;
      end
   end

   // Registered pause indicator, one edge behind the state.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) r_paused <= 1'b0;
      else      r_paused <= (r_state == S_PAUSED);
   end

`ifdef MOVE_SCHED_LEVELUP_EN
   localparam logic [31:0] c_MIN  = 32'(GRAVITY_MIN);
   localparam logic [31:0] c_STEP = 32'(SPEEDUP_STEP);
   localparam logic [7:0]  c_LPL  = 8'(LINES_PER_LEVEL);

   logic [3:0]  r_level;
   logic [7:0]  r_acc;
   logic [7:0]  w_acc_sum;
   logic [31:0] w_dec;

   assign w_acc_sum = r_acc + {5'd0, lines_cleared};

   // Line accumulator with at most one saturating level step per strobe.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         r_level <= 4'd0;
         r_acc   <= 8'd0;
      end else if (lines_valid) begin
         if (w_acc_sum >= c_LPL) begin
            r_acc <= w_acc_sum - c_LPL;
            if (r_level != 4'd15) r_level <= r_level + 4'd1;
         end else begin
            r_acc <= w_acc_sum;
         end
      end
   end

   // A reduction that would go below zero or below the floor clamps to it.
   assign w_dec    = {28'd0, r_level} * c_STEP;
   assign w_period = ((w_dec >= c_INIT) || ((c_INIT - w_dec) < c_MIN)) ?
                     c_MIN : (c_INIT - w_dec);
   assign level    = r_level;
`else
   localparam int c_unused_params = GRAVITY_MIN + SPEEDUP_STEP + LINES_PER_LEVEL;
   logic w_unused_lines;
   assign w_unused_lines = ^{lines_cleared, lines_valid};
   assign w_period       = c_INIT;
   assign level          = 4'd0;
`endif

   assign cmd_if.cmd_valid = r_valid;
   assign cmd_if.cmd       = r_cmd;
   assign paused           = r_paused;

endmodule
`default_nettype wire

// File: tb/tb_move_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_move_scheduler
// Description : Scoreboard bench for move_scheduler. Stimulus pushes expected
//               (command, cycle) pairs; a monitor pops them on every accept.
//               "cycle" is the edge count since reset release after which the
//               accepted command is observed on the bus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_move_scheduler;

   logic       clk = 1'b0;
   logic       clr;
   logic       up, left, right, down, stop, game_over, lines_valid;
   logic [2:0] lines_cleared;
   logic [3:0] level;
   logic       paused;

   typedef struct {
      logic [2:0] cmd;
      int         cyc;
   } exp_t;

   exp_t q[$];
   exp_t m_exp;
   int   checks = 0;
   int   errors = 0;
   int   rel    = 0;

   move_scheduler_if bus ();

   move_scheduler #(
      .GRAVITY_INIT    (20),
      .GRAVITY_MIN     (4),
      .SPEEDUP_STEP    (4),
      .LINES_PER_LEVEL (4)
   ) dut (
      .clk           (clk),
      .clr           (clr),
      .up            (up),
      .left          (left),
      .right         (right),
      .down          (down),
      .stop          (stop),
      .game_over     (game_over),
      .lines_cleared (lines_cleared),
      .lines_valid   (lines_valid),
      .cmd_if        (bus),
      .level         (level),
      .paused        (paused)
   );

   always #5 clk = ~clk;

   // Edge counter relative to reset release.
   always @(posedge clk) begin
      if (clr !== 1'b1) rel <= 0;
      else              rel <= rel + 1;
   end

   // Monitor: every accepted command is compared against the scoreboard head.
   always @(negedge clk) begin
      if (clr === 1'b1 && bus.cmd_valid === 1'b1 && bus.cmd_ready === 1'b1) begin
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_cmd: got cmd %0d at cycle %0d, required no command", bus.cmd, rel);
         end else begin
            m_exp = q.pop_front();
            if (bus.cmd !== m_exp.cmd || rel != m_exp.cyc) begin
               errors++;
               $display("FAIL sb_cmd: got cmd %0d at cycle %0d, required cmd %0d at cycle %0d",
                        bus.cmd, rel, m_exp.cmd, m_exp.cyc);
            end
         end
      end
   end

   task automatic chk(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", name, got, want);
      end
   endtask

   task automatic goto(input int k);
      int n = 0;
      while (rel < k && n < 1000) begin
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   task automatic push(input logic [2:0] c, input int k);
      q.push_back('{c, k});
   endtask

   task automatic drain(input string name, input int maxc);
      int n = 0;
      while (q.size() != 0 && n < maxc) begin
         @(posedge clk);
         n++;
      end
      #1;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL %s_timeout: got %0d pending, required 0", name, q.size());
         q.delete();
      end
   endtask

   task automatic do_reset(input logic rdy);
      clr = 1'b0;
      {up, left, right, down, stop, game_over, lines_valid} = '0;
      lines_cleared = 3'd0;
      bus.cmd_ready = rdy;
      repeat (3) @(posedge clk);
      #1 clr = 1'b1;
   endtask

   // Pulse sampled by edge k.
   task automatic pulse(input int k, input logic u, input logic l,
                        input logic r, input logic d);
      goto(k - 1);
      up = u; left = l; right = r; down = d;
      @(posedge clk);
      #1;
      {up, left, right, down} = '0;
   endtask

   task automatic strobe(input int k, input logic [2:0] n);
      goto(k - 1);
      lines_valid = 1'b1;
      lines_cleared = n;
      @(posedge clk);
      #1;
      lines_valid = 1'b0;
      lines_cleared = 3'd0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, required finish");
      $fatal(1);
   end

   initial begin
      // Free-running gravity with ready tied high.
      do_reset(1'b1);
      chk("rst_cmd_valid", int'(bus.cmd_valid), 0);
      chk("rst_cmd", int'(bus.cmd), 0);
      chk("rst_level", int'(level), 0);
      chk("rst_paused", int'(paused), 0);
      push(3'd1, 21); push(3'd1, 41); push(3'd1, 61);
      goto(20);
      chk("no_early_gravity", int'(bus.cmd_valid), 0);
      drain("gravity_run", 80);

      // Stalled gravity collects left/right/up; release gives back-to-back.
      do_reset(1'b0);
      goto(21);
      chk("gravity_held_valid", int'(bus.cmd_valid), 1);
      pulse(23, 1'b0, 1'b1, 1'b0, 1'b0);
      pulse(24, 1'b0, 1'b0, 1'b1, 1'b0);
      pulse(25, 1'b1, 1'b0, 1'b0, 1'b0);
      goto(26);
      chk("cmd_stable", int'(bus.cmd), 1);
      push(3'd1, 26); push(3'd2, 27); push(3'd4, 28);
      bus.cmd_ready = 1'b1;
      drain("priority", 20);

      // Left+right cancel; soft-drop acceptance restarts the gravity interval.
      do_reset(1'b1);
      pulse(3, 1'b0, 1'b1, 1'b1, 1'b0);
      goto(12);
      chk("lr_cancel", int'(bus.cmd_valid), 0);
      pulse(13, 1'b0, 1'b0, 1'b0, 1'b1);
      push(3'd5, 14); push(3'd1, 36);
      drain("soft_drop", 40);

      // Stop during an unaccepted ROTATE, pause, then resume with frozen timer.
      do_reset(1'b0);
      pulse(3, 1'b1, 1'b0, 1'b0, 1'b0);
      goto(5);
      stop = 1'b1;
      goto(6);
      chk("stop_keeps_valid", int'(bus.cmd_valid), 1);
      chk("stop_keeps_cmd", int'(bus.cmd), 2);
      goto(7);
      push(3'd2, 7);
      bus.cmd_ready = 1'b1;
      goto(9);
      chk("paused_high", int'(paused), 1);
      chk("paused_no_valid", int'(bus.cmd_valid), 0);
      pulse(11, 1'b0, 1'b1, 1'b0, 1'b0);
      pulse(12, 1'b0, 1'b0, 1'b0, 1'b1);
      goto(25);
      chk("paused_no_gravity", int'(bus.cmd_valid), 0);
      goto(30);
      stop = 1'b0;
      goto(32);
      chk("paused_low", int'(paused), 0);
      push(3'd1, 44);
      drain("resume", 40);

      // Level accounting and speed-up.
      do_reset(1'b1);
      strobe(3, 3'd3);
      strobe(5, 3'd2);
`ifdef MOVE_SCHED_LEVELUP_EN
      chk("level_after_5_lines", int'(level), 1);
      push(3'd1, 21); push(3'd1, 37);
      strobe(38, 3'd4);
      strobe(39, 3'd4);
      strobe(40, 3'd4);
      strobe(41, 3'd4);
      chk("level_five", int'(level), 5);
      strobe(42, 3'd3);
      chk("level_six_acc_carry", int'(level), 6);
      push(3'd1, 53); push(3'd1, 57); push(3'd1, 61);
      drain("levelup", 80);
`else
      chk("level_tied_zero", int'(level), 0);
      push(3'd1, 21); push(3'd1, 41);
      drain("fixed_period", 60);
`endif

      // Game over drops an unaccepted command and is sticky until reset.
      do_reset(1'b0);
      goto(22);
      chk("valid_before_over", int'(bus.cmd_valid), 1);
      game_over = 1'b1;
      goto(23);
      chk("over_drops_valid", int'(bus.cmd_valid), 0);
      bus.cmd_ready = 1'b1;
      pulse(26, 1'b1, 1'b0, 1'b0, 1'b0);
      goto(50);
      chk("over_no_cmd", int'(bus.cmd_valid), 0);
      game_over = 1'b0;
      goto(70);
      chk("over_sticky", int'(bus.cmd_valid), 0);

      // Asynchronous reset mid-handshake.
      do_reset(1'b0);
      goto(22);
      chk("valid_before_clr", int'(bus.cmd_valid), 1);
      #2 clr = 1'b0;
      #1;
      chk("async_clr_valid", int'(bus.cmd_valid), 0);
      chk("async_clr_cmd", int'(bus.cmd), 0);
      @(posedge clk);
      #1;
      bus.cmd_ready = 1'b1;
      clr = 1'b1;
      push(3'd1, 21);
      drain("after_clr", 40);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/move_scheduler.md
# move_scheduler

Sequences all piece-motion commands into the game logic. It sits between the button debouncer and the game-logic core, in the logic clock domain. It arbitrates one-cycle move requests (rotate, left, right, soft drop) against a level-dependent gravity timer, and issues exactly one command at a time over a valid/ready handshake. It also owns the pause/stop and game-over sequencing and the speed level.

## Interface
- `GRAVITY_INIT`, default 30_000_000: clock cycles between gravity drops at level 0 (1 s at 30 MHz).
- `GRAVITY_MIN`, default 3_000_000: floor of the gravity period.
- `SPEEDUP_STEP`, default 2_500_000: period reduction per level.
- `LINES_PER_LEVEL`, default 10: cleared lines needed per level increment.
- `clk`  in  1  logic clock.
- `clr`  in  1  asynchronous active-low reset.
- `up`, `left`, `right`, `down`  in  1 each  one-cycle request pulses from the button module. `up` = rotate, `down` = soft drop.
- `stop`  in  1  pause switch, level-sensitive.
- `game_over`  in  1  level from game logic.
- `lines_cleared`  in  3  lines cleared by the last lock (0–4); valid only in the cycle `lines_valid`=1.
- `lines_valid`  in  1  one-cycle strobe.
- `cmd_ready`  in  1  game logic accepts `cmd` this cycle.
- `cmd_valid`  out  1  command offered.
- `cmd`  out  3  0 NONE, 1 GRAVITY, 2 ROTATE, 3 LEFT, 4 RIGHT, 5 SOFT_DROP.
- `level`  out  4  current speed level, saturating at 15.
- `paused`  out  1  high while in PAUSED.

## Operation
- Pending flags: one each for gravity, rotate, horizontal, and soft drop.
  - A request pulse sets its flag. A repeat pulse while the flag is pending coalesces into it.
  - Horizontal is one flag plus a direction bit. A later left/right overwrites the direction. Left and right in the same cycle cancel each other (no change).
  - A flag clears on acceptance.
- Fixed priority: GRAVITY > ROTATE > horizontal > SOFT_DROP.
- Gravity timer:
  - Down-counter, reloaded with `period-1`.
  - On reaching 0 it sets the gravity flag and reloads.
  - Acceptance of SOFT_DROP reloads the counter, so no double drop occurs.
  - `period = max(GRAVITY_INIT - level*SPEEDUP_STEP, GRAVITY_MIN)`. Compute in 32 bits; a negative intermediate clamps to `GRAVITY_MIN`.
  - A new period takes effect at the next reload.
- Level accounting:
  - Each `lines_valid` adds `lines_cleared` to a line accumulator.
  - When the accumulator reaches ≥ `LINES_PER_LEVEL`, subtract `LINES_PER_LEVEL` and increment `level` (saturates at 15; the accumulator still wraps).
  - At most one level step per strobe.
- FSM:
  - **RUN**: timer counts. If any flag is set, register the highest-priority command and go to ISSUE.
  - **ISSUE**: `cmd_valid`=1 and `cmd` is held stable until `cmd_ready`. On accept:
    - if `game_over` → OVER;
    - else if `stop` → PAUSED;
    - else if another flag is pending → stay in ISSUE with the next command (back-to-back);
    - else → RUN.
  - **PAUSED**: timer frozen. Incoming pulses are discarded and all flags are cleared on entry. When `stop` falls → RUN.
  - **OVER**: flags cleared, timer frozen, `cmd_valid`=0. Exit only by reset.
- `game_over` in any state forces OVER on the next edge. It overrides the handshake: `cmd_valid` drops even if the command was unaccepted, and game logic ignores commands once over.
- `stop` raised during ISSUE never retracts `cmd_valid`. The scheduler pauses only after the accept.

## Timing
- Reset values:
  - `cmd_valid`=0, `cmd`=0, `level`=0, `paused`=0;
  - counter=`GRAVITY_INIT-1`, all flags 0, accumulator 0, state RUN.
- A request pulse sampled at edge k gives `cmd_valid`=1 from edge k+1, provided the FSM is in RUN with no higher-priority flag pending.
- Accept at edge a: the next pending command is valid from edge a+1. Sustained throughput is one command per cycle when `cmd_ready` is tied high.
- A pulse arriving in the same cycle its flag is accepted re-sets the flag (it is not lost).
- Gravity expiry fires every `period` cycles while in RUN/ISSUE. ISSUE stalls do not stop the timer. A second expiry while the gravity flag is pending coalesces.
- `paused` is a registered output, high from the edge after entering PAUSED.
- Reset asserted mid-handshake clears `cmd_valid` asynchronously.

## Configuration
- `MOVE_SCHED_LEVELUP_EN`:
  - Defined: level accounting and the speed-up formula as described.
  - Undefined: `level` is tied to 0, `lines_cleared`/`lines_valid` are ignored, and `period` is fixed at `GRAVITY_INIT`.

## Test plan
Bench parameters for all scenarios: `GRAVITY_INIT`=20, `GRAVITY_MIN`=4, `SPEEDUP_STEP`=4, `LINES_PER_LEVEL`=4.
- Release reset, `cmd_ready`=1, no pulses → GRAVITY issued at cycles 20, 40, 60. Outputs are 0 before the first.
- `cmd_ready`=0. Pulse `left` then `right`, then `up`, then let gravity expire → offered order is GRAVITY, ROTATE, RIGHT. A single RIGHT confirms the overwrite. Releasing ready yields one per cycle.
- `left`+`right` in the same cycle → no horizontal command. SOFT_DROP accepted at cycle 15 → next GRAVITY at cycle 35.
- `stop`=1 while ROTATE is offered unaccepted → `cmd_valid` held. After accept, `paused`=1 and pulses are ignored. `stop`=0 → timer resumes from its frozen value.
- `MOVE_SCHED_LEVELUP_EN` defined: strobes of 3 then 2 lines → `level`=1, accumulator=1, and the next period is 16. Five levels reach the period floor of 4. `game_over`=1 → `cmd_valid`=0 next cycle and stays 0.
- Assert `clr` while `cmd_valid`=1 → all outputs 0 immediately. The first GRAVITY comes 20 cycles after release.
